// File: rtl/uart_word_loader.sv
// ---------------------------------------------------------------------------
// uart_word_loader
//
// Receives a UART byte stream and packs WORD_BYTES bytes into one word. Each
// completed word is strobed for one cycle together with an auto-incrementing
// write address, so the outputs can drive an instruction-memory write port.
//
// Optional build macro: UART_PARITY_EN
//   defined   -> 8E1 frames, parity_err reports even-parity mismatches
//   undefined -> 8N1 frames, parity_err is constant 0
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active low
//   rx           asynchronous UART line, idle high
//   addr_clr     synchronous request to return word_addr to 0
//   word_out     last completed word (held until the next one)
//   word_valid   one-cycle strobe, word_out/word_addr valid
//   word_addr    address of the word currently strobed
//   frame_err    one-cycle pulse, stop bit read 0 (byte dropped)
//   timeout_err  one-cycle pulse, partial word discarded after idle time
//   parity_err   one-cycle pulse, parity mismatch (byte dropped)
// ---------------------------------------------------------------------------
module uart_word_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD_BYTES   = 4,
    parameter bit MSB_FIRST    = 1,
    parameter int ADDR_W       = 10,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    input  logic                    addr_clr,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic                    word_valid,
    output logic [ADDR_W-1:0]       word_addr,
    output logic                    frame_err,
    output logic                    timeout_err,
    output logic                    parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int BI_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                  state_reg;
    logic                    rx_meta_reg;
    logic                    rx_sync_reg;
    logic [CNT_W-1:0]        clk_cnt_reg;
    logic [2:0]              bit_idx_reg;
    logic [7:0]              shift_reg;
    logic [BI_W-1:0]         byte_idx_reg;
    logic [TO_W-1:0]         to_cnt_reg;
    logic [8*WORD_BYTES-1:0] word_buf_reg;
    logic [8*WORD_BYTES-1:0] word_out_reg;
    logic [8*WORD_BYTES-1:0] word_next;
    logic [ADDR_W-1:0]       addr_reg;
    logic                    valid_reg;
    logic                    frame_err_reg;
    logic                    timeout_err_reg;
    logic                    bit_end;
    logic                    half_end;
    logic                    stop_sample;
    logic                    byte_ok;
    logic                    last_slot;

    assign bit_end     = (clk_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
    assign half_end    = (clk_cnt_reg == CNT_W'(HALF - 1));
    assign stop_sample = (state_reg == S_STOP) && bit_end;
    assign last_slot   = (byte_idx_reg == BI_W'(WORD_BYTES - 1));

`ifdef UART_PARITY_EN
    logic par_bad_reg;
    logic parity_err_reg;
    assign byte_ok    = stop_sample && rx_sync_reg && !par_bad_reg;
    assign parity_err = parity_err_reg;
`else
    assign byte_ok    = stop_sample && rx_sync_reg;
    assign parity_err = 1'b0;
`endif

    // Merge the byte just received into its slot of the assembly buffer.
    // Slot placement depends on byte order; all other slots pass through.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi = gi + 1) begin : g_slot
            localparam int LSB = MSB_FIRST ? 8 * (WORD_BYTES - 1 - gi) : 8 * gi;
            assign word_next[LSB +: 8] = (byte_idx_reg == BI_W'(gi)) ?
                                         shift_reg : word_buf_reg[LSB +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            rx_meta_reg     <= 1'b1;
            rx_sync_reg     <= 1'b1;
            clk_cnt_reg     <= '0;
            bit_idx_reg     <= '0;
            shift_reg       <= '0;
            byte_idx_reg    <= '0;
            to_cnt_reg      <= '0;
            word_buf_reg    <= '0;
            word_out_reg    <= '0;
            addr_reg        <= '0;
            valid_reg       <= 1'b0;
            frame_err_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad_reg     <= 1'b0;
            parity_err_reg  <= 1'b0;
`endif
        end else begin
            rx_meta_reg     <= rx;
            rx_sync_reg     <= rx_meta_reg;
            valid_reg       <= 1'b0;
            frame_err_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_reg  <= 1'b0;
`endif

            // ---------------- receiver ----------------
            case (state_reg)
                S_IDLE: begin
                    clk_cnt_reg <= '0;
                    if (!rx_sync_reg) state_reg <= S_START;
                end
                S_START: begin
                    if (half_end) begin
                        // A line that is high again at mid start bit was a glitch.
                        clk_cnt_reg <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rx_sync_reg ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt_reg <= '0;
                        shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_reg <= S_PARITY;
`else
                            state_reg <= S_STOP;
`endif
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        clk_cnt_reg <= '0;
                        par_bad_reg <= (^shift_reg) ^ rx_sync_reg;
                        state_reg   <= S_STOP;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        // Back to IDLE at mid stop bit so the next start edge is not missed.
                        clk_cnt_reg <= '0;
                        state_reg   <= S_IDLE;
                        if (!rx_sync_reg) frame_err_reg <= 1'b1;
`ifdef UART_PARITY_EN
                        else if (par_bad_reg) parity_err_reg <= 1'b1;
`endif
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            // ---------------- assembler / timeout ----------------
            // An accepted byte has priority over a timeout in the same cycle.
            if (byte_ok) begin
                word_buf_reg <= word_next;
                to_cnt_reg   <= '0;
                if (last_slot) begin
                    word_out_reg <= word_next;
                    valid_reg    <= 1'b1;
                end else begin
                    byte_idx_reg <= byte_idx_reg + BI_W'(1);
                end
            end else if (stop_sample) begin
                // Rejected byte (framing or parity) also discards the partial word.
                byte_idx_reg <= '0;
                to_cnt_reg   <= '0;
            end else if (valid_reg) begin
                byte_idx_reg <= '0;
                to_cnt_reg   <= '0;
            end else if (byte_idx_reg == '0) begin
                to_cnt_reg <= '0;
            end else if (to_cnt_reg == TO_W'(TIMEOUT_CLKS - 1)) begin
                byte_idx_reg    <= '0;
                to_cnt_reg      <= '0;
                timeout_err_reg <= 1'b1;
            end else begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end

            // ---------------- address ----------------
            // The strobed word keeps its address; the clear affects the next one.
            if (addr_clr)       addr_reg <= '0;
            else if (valid_reg) addr_reg <= addr_reg + ADDR_W'(1);
        end
    end

    assign word_out    = word_out_reg;
    assign word_valid  = valid_reg;
    assign word_addr   = addr_reg;
    assign frame_err   = frame_err_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_uart_word_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_word_loader
//
// Two loaders (MSB-first and LSB-first) listen to the same serial line. The
// bench keeps a byte-level model (queue of received bytes, word address
// counter) and compares every strobed word, its address, the address one
// cycle later and the error pulse counts against it.
// ---------------------------------------------------------------------------
module tb_uart_word_loader;

    localparam int CPB  = 16;
    localparam int WB   = 4;
    localparam int AW   = 4;
    localparam int TOC  = 2000;

    logic          clk;
    logic          rst;
    logic          rx;
    logic          addr_clr;
    logic [31:0]   m_word, l_word;
    logic          m_valid, l_valid;
    logic [AW-1:0] m_addr, l_addr;
    logic          m_frame, l_frame, m_to, l_to, m_par, l_par;

    uart_word_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .MSB_FIRST(1),
                       .ADDR_W(AW), .TIMEOUT_CLKS(TOC)) dut_msb (
        .clk(clk), .rst(rst), .rx(rx), .addr_clr(addr_clr),
        .word_out(m_word), .word_valid(m_valid), .word_addr(m_addr),
        .frame_err(m_frame), .timeout_err(m_to), .parity_err(m_par));

    uart_word_loader #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .MSB_FIRST(0),
                       .ADDR_W(AW), .TIMEOUT_CLKS(TOC)) dut_lsb (
        .clk(clk), .rst(rst), .rx(rx), .addr_clr(addr_clr),
        .word_out(l_word), .word_valid(l_valid), .word_addr(l_addr),
        .frame_err(l_frame), .timeout_err(l_to), .parity_err(l_par));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0]   wm;
        logic [31:0]   wl;
        logic [AW-1:0] a;
        logic [AW-1:0] na;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  part_q[$];
    int          addr_m    = 0;
    int          frame_exp = 0, to_exp = 0;
    int          frame_seen = 0, to_seen = 0, par_seen = 0;
    bit          clr_arm   = 0;

    task automatic model_byte(input logic [7:0] b, input logic stop_bit);
        exp_t e;
        if (!stop_bit) begin
            frame_exp++;
            part_q.delete();
        end else begin
            part_q.push_back(b);
            if (part_q.size() == WB) begin
                e.wm = {part_q[0], part_q[1], part_q[2], part_q[3]};
                e.wl = {part_q[3], part_q[2], part_q[1], part_q[0]};
                e.a  = AW'(addr_m);
                addr_m = clr_arm ? 0 : (addr_m + 1) % (1 << AW);
                e.na = AW'(addr_m);
                exp_q.push_back(e);
                part_q.delete();
            end
        end
    endtask

    // ---------------- line driver ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        $display("tx byte %02h stop=%0b", b, stop_bit);
        rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(CPB);
        end
        // Model updated before the stop bit: the strobe appears mid stop bit.
        model_byte(b, stop_bit);
        rx = stop_bit;
        cyc(CPB);
        rx = 1'b1;
        cyc(2);
    endtask

    task automatic idle(input int n);
        cyc(n);
        if (part_q.size() > 0 && n > TOC + 20) begin
            part_q.delete();
            to_exp++;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[8*k +: 8], 1'b1);
            idle($urandom_range(0, 40));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_msb"}, {m_word, m_valid, m_addr, m_frame, m_to, m_par}, 64'd0);
        check({tag, "_lsb"}, {l_word, l_valid, l_addr, l_frame, l_to, l_par}, 64'd0);
    endtask

    // ---------------- monitor ----------------
    exp_t          mon_e;
    bit            chk_next = 0;
    logic [AW-1:0] next_exp;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk_next = 0;
            end else begin
                if (chk_next) begin
                    check("addr_next", m_addr, next_exp);
                    chk_next = 0;
                end
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        $display("word msb=%08h lsb=%08h addr=%0d", m_word, l_word, m_addr);
                        check("word_msb", m_word, mon_e.wm);
                        check("word_lsb", l_word, mon_e.wl);
                        check("addr_msb", m_addr, mon_e.a);
                        check("addr_lsb", l_addr, mon_e.a);
                        check("valid_lsb", l_valid, 1);
                        chk_next = 1;
                        next_exp = mon_e.na;
                    end
                end
                if (m_frame) frame_seen++;
                if (m_to)    to_seen++;
                if (m_par || l_par) par_seen++;
            end
        end
    end

    // addr_clr is raised in the strobe cycle of the armed word.
    initial begin
        addr_clr = 1'b0;
        forever begin
            @(negedge clk);
            if (clr_arm && m_valid && rst) begin
                addr_clr = 1'b1;
                @(negedge clk);
                addr_clr = 1'b0;
                clr_arm  = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        cyc(5);
        @(negedge clk);
        check_reset_outputs("reset");
        cyc(1);
        rst = 1'b1;
        cyc(5);

        // Directed word in both byte orders.
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        idle(10);
        check("direct_msb", m_word, 32'h12345678);
        check("direct_lsb", l_word, 32'h78563412);

        // Short low glitch: no byte, no error.
        rx = 1'b0;
        cyc(5);
        rx = 1'b1;
        idle(100);

        // Timeout discards AA,BB.
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        idle(2500);
        check("timeout_count", to_seen, to_exp);
        send_word(32'h01020304);
        idle(10);
        check("after_timeout", m_word, 32'h01020304);

        // Framing error on the last byte of a word.
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b0);
        idle(20);
        check("frame_count", frame_seen, frame_exp);
        send_word(32'hCAFEF00D);

        // Random words, enough to wrap the 4-bit address.
        for (int n = 0; n < 20; n++) send_word($urandom);

        // Reset in the middle of the third byte of a word.
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = 1'($urandom_range(0, 1));
            cyc(CPB);
        end
        rst = 1'b0;
        rx  = 1'b1;
        part_q.delete();
        addr_m = 0;
        cyc(3);
        @(negedge clk);
        check_reset_outputs("midbyte_reset");
        cyc(1);
        rst = 1'b1;
        cyc(5);

        // Seven words to reach address 7, then addr_clr on that strobe.
        for (int n = 0; n < 7; n++) send_word($urandom);
        clr_arm = 1;
        send_word(32'h77777777);
        send_word(32'h0BADBEEF);

        idle(50);
        check("pending_words", exp_q.size(), 0);
        check("frame_total", frame_seen, frame_exp);
        check("timeout_total", to_seen, to_exp);
        check("parity_total", par_seen, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
